// File: rtl/div_tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared constants and helpers for the divider / tick generator.
//   tap_idx_w()    : width of one channel's tap-select field for a given
//                    divider width ($clog2 of the width)
//   TAP_IDX_W      : tap-select width for the default 16-bit divider
//   SEQ_TAP_NORMAL : divider bit that clocks the frame sequencer at normal speed
//   SEQ_TAP_DOUBLE : divider bit that clocks it at double speed
// -----------------------------------------------------------------------------
package div_pkg;

   localparam int DIV_WIDTH_DEFAULT = 16;
   localparam int SEQ_TAP_NORMAL    = 12;
   localparam int SEQ_TAP_DOUBLE    = SEQ_TAP_NORMAL + 1;

   function automatic int tap_idx_w(input int div_width);
      return $clog2(div_width);
   endfunction

   localparam int TAP_IDX_W = tap_idx_w(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/div_tick_gen_if.sv
// -----------------------------------------------------------------------------
// div_tick_gen_if
// CPU-side register port of the divider.
//   div_wr  : write strobe, clears the divider
//   div_rd  : read strobe
//   dout    : top 8 bits of the divider
//   dout_oe : output enable, follows div_rd
// master = CPU side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_tick_gen_if;

   logic       div_wr;
   logic       div_rd;
   logic [7:0] dout;
   logic       dout_oe;

   modport master (
      output div_wr,
      output div_rd,
      input  dout,
      input  dout_oe
   );

   modport slave (
      input  div_wr,
      input  div_rd,
      output dout,
      output dout_oe
   );

endinterface

// File: rtl/div_tick_gen_fall_edge_det.sv
// -----------------------------------------------------------------------------
// fall_edge_det
// Registers a level and flags the cycle in which it is seen dropping.
//   clk     : system clock
//   clr_i   : synchronous clear of the stored level
//   sig_i   : level to watch
//   pulse_o : high while the stored level is 1 and sig_i is 0
// The pulse is combinational from sig_i so it lines up with the first cycle
// the source shows the low level.
// -----------------------------------------------------------------------------
module fall_edge_det (
   input  logic clk,
   input  logic clr_i,
   input  logic sig_i,
   output logic pulse_o
);

   logic sig_q;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign pulse_o = sig_q & ~sig_i;

endmodule

// File: rtl/div_tick_gen.sv
// -----------------------------------------------------------------------------
// div_tick_gen
// Free-running divider with CPU read/clear, NUM_TAPS falling-edge tick
// channels, a frame-sequencer step counter and a reset stretcher.
//   clk        : system clock
//   reset      : synchronous, active-high
//   ce         : divider count enable
//   cpu        : CPU register port (div_wr clears, dout = top 8 bits)
//   tap_sel    : per-channel divider bit index, TAP_W bits per channel
//   tap_en     : per-channel enable
//   tick       : per-channel one-cycle pulse on a falling tapped bit
//   dbl        : double speed, sequencer watches bit SEQ_TAP+1
//   seq_step   : frame-sequencer step
//   seq_tick   : registered pulse in the cycle seq_step changes
//   nreset_out : active-low reset, held low RST_STRETCH cycles after reset
// DIV_WIDTH must be at least 9, SEQ_TAP+1 must be below DIV_WIDTH and
// RST_STRETCH must be at least 1.
// -----------------------------------------------------------------------------
module div_tick_gen
   import div_pkg::*;
#(
   parameter int DIV_WIDTH   = 16,
   parameter int NUM_TAPS    = 4,
   parameter int SEQ_TAP     = SEQ_TAP_NORMAL,
   parameter int SEQ_WIDTH   = 3,
   parameter int RST_STRETCH = 4,
   localparam int TAP_W      = tap_idx_w(DIV_WIDTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ce,
   div_tick_gen_if.slave             cpu,
   input  logic [NUM_TAPS*TAP_W-1:0] tap_sel,
   input  logic [NUM_TAPS-1:0]       tap_en,
   output logic [NUM_TAPS-1:0]       tick,
   input  logic                      dbl,
   output logic [SEQ_WIDTH-1:0]      seq_step,
   output logic                      seq_tick,
   output logic                      nreset_out
);

   // Index space reachable by a tap_sel field; indices past the divider
   // read the zero padding so an out-of-range channel never ticks.
   localparam int EXT_W  = 1 << TAP_W;
   localparam int RCNT_W = $clog2(RST_STRETCH + 1);
   localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(RST_STRETCH);

   // ---------------------------------------------------------------- divider
   logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;

   always_comb begin
      div_cnt_d = div_cnt_q;
      if (cpu.div_wr) begin
         div_cnt_d = '0;               // CPU clear wins over counting
      end else if (ce) begin
         div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   assign cpu.dout    = div_cnt_q[DIV_WIDTH-1 -: 8];
   assign cpu.dout_oe = cpu.div_rd;

   logic [EXT_W-1:0] cnt_ext;

   always_comb begin
      cnt_ext                 = '0;
      cnt_ext[DIV_WIDTH-1:0]  = div_cnt_q;
   end

   // ---------------------------------------------------------- tick channels
   // Any drop of the gated level ticks, including a clear, an enable drop or
   // a select change away from a set bit; consumers rely on that behaviour.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_TAPS; gi++) begin : g_ch
         logic [TAP_W-1:0] sel;
         logic             sig;

         assign sel = tap_sel[gi*TAP_W +: TAP_W];
         assign sig = tap_en[gi] & cnt_ext[sel];

         fall_edge_det u_edge (
            .clk     (clk),
            .clr_i   (reset),
            .sig_i   (sig),
            .pulse_o (tick[gi])
         );
      end
   endgenerate

   // -------------------------------------------------------- frame sequencer
   logic                 seq_sig;
   logic                 seq_fall;
   logic [SEQ_WIDTH-1:0] seq_step_q, seq_step_d;
   logic                 seq_tick_q;

   // Switching dbl can itself create a falling edge and advance the step.
   assign seq_sig = dbl ? div_cnt_q[SEQ_TAP+1] : div_cnt_q[SEQ_TAP];

   fall_edge_det u_seq_edge (
      .clk     (clk),
      .clr_i   (reset),
      .sig_i   (seq_sig),
      .pulse_o (seq_fall)
   );

   always_comb begin
      seq_step_d = seq_step_q;
      if (seq_fall) begin
         seq_step_d = seq_step_q + SEQ_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seq_step_q <= '0;
         seq_tick_q <= 1'b0;
      end else begin
         seq_step_q <= seq_step_d;
         seq_tick_q <= seq_fall;
      end
   end

   assign seq_step = seq_step_q;
   assign seq_tick = seq_tick_q;

   // ---------------------------------------------------------- reset stretch
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic              nreset_q;

   always_comb begin
      rcnt_d = rcnt_q;
      if (rcnt_q != RCNT_MAX) begin
         rcnt_d = rcnt_q + RCNT_W'(1);
      end
   end

   // Registered from the next count so nreset_out rises on the same edge
   // that the counter reaches RST_STRETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         rcnt_q   <= '0;
         nreset_q <= 1'b0;
      end else begin
         rcnt_q   <= rcnt_d;
         nreset_q <= (rcnt_d == RCNT_MAX);
      end
   end

   assign nreset_out = nreset_q;

endmodule

// File: tb/tb_div_tick_gen.sv
module tb_div_tick_gen;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        ce;
   logic        dbl;
   logic [15:0] tap_sel;
   logic [3:0]  tap_en;
   logic [3:0]  tick;
   logic [2:0]  seq_step;
   logic        seq_tick;
   logic        nreset_out;

   div_tick_gen_if cpu_if ();

   div_tick_gen #(
      .DIV_WIDTH   (16),
      .NUM_TAPS    (4),
      .SEQ_TAP     (12),
      .SEQ_WIDTH   (3),
      .RST_STRETCH (4)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .ce         (ce),
      .cpu        (cpu_if),
      .tap_sel    (tap_sel),
      .tap_en     (tap_en),
      .tick       (tick),
      .dbl        (dbl),
      .seq_step   (seq_step),
      .seq_tick   (seq_tick),
      .nreset_out (nreset_out)
   );

   // Second instance with a 12-bit divider so a tap index beyond the
   // divider (13) is representable in the 4-bit select field.
   logic [7:0]  tap_sel2;
   logic [1:0]  tap_en2;
   logic [1:0]  tick2;
   logic [2:0]  seq_step2;
   logic        seq_tick2;
   logic        nreset_out2;

   div_tick_gen_if cpu2_if ();
   assign cpu2_if.div_wr = 1'b0;
   assign cpu2_if.div_rd = 1'b0;

   div_tick_gen #(
      .DIV_WIDTH   (12),
      .NUM_TAPS    (2),
      .SEQ_TAP     (9),
      .SEQ_WIDTH   (3),
      .RST_STRETCH (1)
   ) u_dut2 (
      .clk        (clk),
      .reset      (reset),
      .ce         (1'b1),
      .cpu        (cpu2_if),
      .tap_sel    (tap_sel2),
      .tap_en     (tap_en2),
      .tick       (tick2),
      .dbl        (1'b0),
      .seq_step   (seq_step2),
      .seq_tick   (seq_tick2),
      .nreset_out (nreset_out2)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic do_reset();
      @(negedge clk);
      reset          = 1'b1;
      ce             = 1'b0;
      dbl            = 1'b0;
      tap_sel        = '0;
      tap_en         = '0;
      cpu_if.div_wr  = 1'b0;
      cpu_if.div_rd  = 1'b0;
      @(negedge clk);
      reset          = 1'b0;
   endtask

   task automatic test_reset();
      logic exp;
      reset         = 1'b1;
      ce            = 1'b1;
      dbl           = 1'b0;
      tap_sel       = 16'h0003;
      tap_en        = 4'b1111;
      cpu_if.div_wr = 1'b0;
      cpu_if.div_rd = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (cpu_if.dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", cpu_if.dout); end
      n_vec++; if (nreset_out !== 1'b0) begin n_err++; $display("FAIL reset_nrst: got %b want 0", nreset_out); end
      n_vec++; if (tick !== 4'b0000) begin n_err++; $display("FAIL reset_tick: got %b want 0000", tick); end
      n_vec++; if ({seq_step, seq_tick} !== 4'b0000) begin n_err++; $display("FAIL reset_seq: got step %0d tick %b want 0 0", seq_step, seq_tick); end
      reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         exp = (k == 4);
         n_vec++; if (nreset_out !== exp) begin n_err++; $display("FAIL release_nrst edge %0d: got %b want %b", k, nreset_out, exp); end
      end
   endtask

   task automatic test_read();
      do_reset();
      ce            = 1'b1;
      cpu_if.div_rd = 1'b1;
      #1;
      n_vec++; if (cpu_if.dout_oe !== 1'b1) begin n_err++; $display("FAIL read_oe_on: got %b want 1", cpu_if.dout_oe); end
      repeat (255) @(negedge clk);
      n_vec++; if (cpu_if.dout !== 8'h00) begin n_err++; $display("FAIL read_255: got %h want 00", cpu_if.dout); end
      @(negedge clk);
      n_vec++; if (cpu_if.dout !== 8'h01) begin n_err++; $display("FAIL read_256: got %h want 01", cpu_if.dout); end
      repeat (512) @(negedge clk);
      n_vec++; if (cpu_if.dout !== 8'h03) begin n_err++; $display("FAIL read_768: got %h want 03", cpu_if.dout); end
      cpu_if.div_wr = 1'b1;
      @(negedge clk);
      n_vec++; if (cpu_if.dout !== 8'h00) begin n_err++; $display("FAIL read_clear: got %h want 00", cpu_if.dout); end
      cpu_if.div_wr = 1'b0;
      cpu_if.div_rd = 1'b0;
      #1;
      n_vec++; if (cpu_if.dout_oe !== 1'b0) begin n_err++; $display("FAIL read_oe_off: got %b want 0", cpu_if.dout_oe); end
   endtask

   task automatic test_div_wr();
      int cnt;
      do_reset();
      tap_sel = 16'h0003;
      tap_en  = 4'b0001;
      ce      = 1'b1;
      repeat (8) @(negedge clk);            // div = 8, bit 3 set
      n_vec++; if (tick !== 4'b0000) begin n_err++; $display("FAIL wr_before: got %b want 0000", tick); end
      cpu_if.div_wr = 1'b1;
      @(negedge clk);                       // div cleared to 0, not 1
      n_vec++; if (tick !== 4'b0001) begin n_err++; $display("FAIL wr_clear_tick: got %b want 0001", tick); end
      cpu_if.div_wr = 1'b0;
      cnt = 0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         cnt += int'(tick[0]);
      end
      n_vec++; if (cnt !== 0) begin n_err++; $display("FAIL wr_gap: got %0d ticks want 0", cnt); end
      @(negedge clk);                       // div = 16
      n_vec++; if (tick !== 4'b0001) begin n_err++; $display("FAIL wr_next_tick: got %b want 0001", tick); end
   endtask

   task automatic test_tap_en();
      do_reset();
      tap_sel = 16'h0020;                   // channel 1 watches bit 2
      tap_en  = 4'b0010;
      ce      = 1'b1;
      repeat (4) @(negedge clk);            // div = 4, bit 2 set
      ce = 1'b0;
      @(negedge clk);
      n_vec++; if (tick !== 4'b0000) begin n_err++; $display("FAIL en_hold: got %b want 0000", tick); end
      tap_en = 4'b0000;
      #1;
      n_vec++; if (tick !== 4'b0010) begin n_err++; $display("FAIL en_drop_hi: got %b want 0010", tick); end
      @(negedge clk);
      n_vec++; if (tick !== 4'b0000) begin n_err++; $display("FAIL en_drop_after: got %b want 0000", tick); end
      tap_en = 4'b0010;
      #1;
      n_vec++; if (tick !== 4'b0000) begin n_err++; $display("FAIL en_raise: got %b want 0000", tick); end
      @(negedge clk);
      tap_sel = 16'h0000;                   // move to bit 0, which is 0
      #1;
      n_vec++; if (tick !== 4'b0010) begin n_err++; $display("FAIL sel_change: got %b want 0010", tick); end
      @(negedge clk);
      tap_en = 4'b0000;                     // level already 0
      #1;
      n_vec++; if (tick !== 4'b0000) begin n_err++; $display("FAIL en_drop_lo: got %b want 0000", tick); end
      @(negedge clk);
      n_vec++; if (tick !== 4'b0000) begin n_err++; $display("FAIL en_drop_lo_after: got %b want 0000", tick); end
   endtask

   task automatic test_stretch();
      logic exp;
      do_reset();
      ce = 1'b1;
      repeat (2) @(negedge clk);            // stretch count at 2
      n_vec++; if (nreset_out !== 1'b0) begin n_err++; $display("FAIL mid_stretch: got %b want 0", nreset_out); end
      reset = 1'b1;
      @(negedge clk);
      n_vec++; if (nreset_out !== 1'b0) begin n_err++; $display("FAIL restretch_rst: got %b want 0", nreset_out); end
      n_vec++; if ({cpu_if.dout, seq_step, tick} !== 15'd0) begin n_err++; $display("FAIL restretch_zero: got dout %h step %0d tick %b want 0", cpu_if.dout, seq_step, tick); end
      reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         exp = (k == 4);
         n_vec++; if (nreset_out !== exp) begin n_err++; $display("FAIL restretch edge %0d: got %b want %b", k, nreset_out, exp); end
      end
   endtask

   task automatic test_wrap_seq();
      int c0, c1, c2, c3, cs, d0, d1;
      c0 = 0; c1 = 0; c2 = 0; c3 = 0; cs = 0; d0 = 0; d1 = 0;
      do_reset();
      tap_sel = {4'd0, 4'd15, 4'd7, 4'd3};
      tap_en  = 4'b0111;
      ce      = 1'b1;
      for (int n = 1; n <= 65537; n++) begin
         @(negedge clk);                    // div = n mod 65536
         c0 += int'(tick[0]);
         c1 += int'(tick[1]);
         c2 += int'(tick[2]);
         c3 += int'(tick[3]);
         cs += int'(seq_tick);
         d0 += int'(tick2[0]);
         d1 += int'(tick2[1]);
         if (n == 15) begin
            n_vec++; if (tick !== 4'b0000) begin n_err++; $display("FAIL ch0_pre: got %b want 0000", tick); end
         end
         if (n == 16) begin
            n_vec++; if (tick !== 4'b0001) begin n_err++; $display("FAIL ch0_first: got %b want 0001", tick); end
         end
         if (n == 8192) begin
            n_vec++; if ({seq_step, seq_tick} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL seq_pre: got step %0d tick %b want 0 0", seq_step, seq_tick); end
         end
         if (n == 8193) begin
            n_vec++; if ({seq_step, seq_tick} !== {3'd1, 1'b1}) begin n_err++; $display("FAIL seq_first: got step %0d tick %b want 1 1", seq_step, seq_tick); end
         end
         if (n == 57345) begin
            n_vec++; if ({seq_step, seq_tick} !== {3'd7, 1'b1}) begin n_err++; $display("FAIL seq_seven: got step %0d tick %b want 7 1", seq_step, seq_tick); end
         end
         if (n == 65535) begin
            n_vec++; if ({cpu_if.dout, tick} !== {8'hFF, 4'b0000}) begin n_err++; $display("FAIL all_ones: got dout %h tick %b want ff 0000", cpu_if.dout, tick); end
         end
         if (n == 65536) begin
            n_vec++; if ({cpu_if.dout, tick} !== {8'h00, 4'b0111}) begin n_err++; $display("FAIL wrap: got dout %h tick %b want 00 0111", cpu_if.dout, tick); end
         end
         if (n == 65537) begin
            n_vec++; if ({seq_step, seq_tick} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL seq_wrap: got step %0d tick %b want 0 1", seq_step, seq_tick); end
         end
      end
      n_vec++; if (c0 !== 4096) begin n_err++; $display("FAIL cnt_ch0: got %0d want 4096", c0); end
      n_vec++; if (c1 !== 256) begin n_err++; $display("FAIL cnt_ch1: got %0d want 256", c1); end
      n_vec++; if (c2 !== 1) begin n_err++; $display("FAIL cnt_ch2: got %0d want 1", c2); end
      n_vec++; if (c3 !== 0) begin n_err++; $display("FAIL cnt_ch3: got %0d want 0", c3); end
      n_vec++; if (cs !== 8) begin n_err++; $display("FAIL cnt_seq: got %0d want 8", cs); end
      n_vec++; if (d0 !== 16) begin n_err++; $display("FAIL cnt_dut2_in: got %0d want 16", d0); end
      n_vec++; if (d1 !== 0) begin n_err++; $display("FAIL cnt_dut2_oor: got %0d want 0", d1); end
   endtask

   task automatic test_dbl();
      int cs;
      cs = 0;
      do_reset();
      ce  = 1'b1;
      dbl = 1'b1;
      repeat (4096) @(negedge clk);         // div = 0x1000: bit12=1, bit13=0
      ce  = 1'b0;
      dbl = 1'b0;                           // 0 -> 1 on the watched bit
      @(negedge clk);
      n_vec++; if ({seq_step, seq_tick} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL dbl_off: got step %0d tick %b want 0 0", seq_step, seq_tick); end
      dbl = 1'b1;                           // 1 -> 0 on the watched bit
      @(negedge clk);
      n_vec++; if ({seq_step, seq_tick} !== {3'd1, 1'b1}) begin n_err++; $display("FAIL dbl_toggle: got step %0d tick %b want 1 1", seq_step, seq_tick); end
      ce = 1'b1;
      for (int n = 4097; n <= 16385; n++) begin
         @(negedge clk);                    // div = n
         cs += int'(seq_tick);
         if (n == 8193) begin
            n_vec++; if ({seq_step, seq_tick} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL dbl_8193: got step %0d tick %b want 1 0", seq_step, seq_tick); end
         end
         if (n == 16385) begin
            n_vec++; if ({seq_step, seq_tick} !== {3'd2, 1'b1}) begin n_err++; $display("FAIL dbl_16385: got step %0d tick %b want 2 1", seq_step, seq_tick); end
         end
      end
      n_vec++; if (cs !== 1) begin n_err++; $display("FAIL dbl_cnt: got %0d want 1", cs); end
   endtask

   initial begin
      tap_sel2 = {4'd13, 4'd11};
      tap_en2  = 2'b11;
      test_reset();
      test_read();
      test_div_wr();
      test_tap_en();
      test_stretch();
      test_wrap_seq();
      test_dbl();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
